mem_arb_sram: RTL and testbench
===============================

// Module: mem_arb_sram
// PURPOSE
//  Shared word memory behind a 2-master arbiter. Downstream consumer of the UART bridge's req/gnt/rvalid bus (m0).
//  A second master (m1, e.g. CPU/fabric port) uses the same bus. One transaction is in flight at a time.
//  Responses arrive a fixed number of cycles after grant.
// PARAMETERS
//  ADDR_WIDTH   12  word address width; array depth = 2**ADDR_WIDTH x 32 bit
//  WAIT_CYCLES  0   extra response latency, range 0..3; rvalid arrives WAIT_CYCLES+1 cycles after gnt
// PORTS
//  clk_i        in   1           single clock, all logic on posedge
//  rst_i        in   1           synchronous, active-high reset
//  mN_req_i     in   1           (N=0,1) request; held with addr/we/be/wdata stable until gnt
//  mN_addr_i    in   ADDR_WIDTH  word address
//  mN_we_i      in   1           1=write, 0=read
//  mN_be_i      in   4           byte enables; be[i] selects wdata[8i+7:8i]
//  mN_wdata_i   in   32          write data
//  mN_gnt_o     out  1           request accepted this cycle (combinational from req and state)
//  mN_rvalid_o  out  1           one-cycle response pulse
//  mN_rdata_o   out  32          read data; valid only while mN_rvalid_o=1
// BEHAVIOUR
//  Reset: state=IDLE, last_grant=1, all gnt/rvalid=0, rdata=0. Memory contents are not cleared.
//  FSM IDLE -> (WAIT when WAIT_CYCLES>0) -> RESP -> IDLE.
//   IDLE: when any req=1, grant exactly one master this cycle.
//    - Capture master index, we and address.
//    - Perform the array access at this clock edge: a write commits its enabled bytes; a read latches the word.
//    - Next state is WAIT (counter loaded with WAIT_CYCLES-1), or RESP if WAIT_CYCLES=0.
//   WAIT: decrement the counter; go to RESP when it reaches 0. No gnt is issued.
//   RESP: drive rvalid=1 for exactly one cycle to the captured master; next state is IDLE.
//    - Read: rdata = the word latched at grant.
//    - Write: rdata = 0 (the write is acknowledged anyway).
//    - No gnt is issued in RESP.
//  Timing: gnt at cycle T; rvalid at T+WAIT_CYCLES+1; the earliest next gnt is at T+WAIT_CYCLES+2.
//  rvalid is never in the same cycle as gnt. The UART master samples rvalid only after gnt.
//  Arbitration (default): round-robin.
//   - Both req in IDLE: grant the master that is not last_grant.
//   - Single req: grant that master.
//   - last_grant updates on every grant.
//   - The first contested grant after reset goes to m0.
//  Requests seen outside IDLE stay pending; they are neither dropped nor granted early.
//  be=4'b0000 write: granted and acknowledged; memory is unchanged.
//  Reset asserted mid-transaction (WAIT/RESP): back to IDLE, the pending rvalid is discarded.
//   A write granted before reset stays committed.
//  The address covers the full array; no out-of-range case exists.
// CONFIGURATION
//  MEM_ARB_FIXED_PRIO_EN defined: fixed priority.
//   - m0 (UART debug path) wins every contested IDLE cycle; last_grant is unused.
//   - m1 can starve while m0 keeps requesting.
//  MEM_ARB_FIXED_PRIO_EN undefined: round-robin as above.
// STRUCTURE
//  Package mem_arb_pkg:
//   - state enum {IDLE, WAIT, RESP}
//   - master index constants M_UART=0, M_CPU=1
//   - WORD_W=32, BE_W=4
//  Sub-module sram_word_be: 1RW synchronous array with per-byte write enable and registered read data.
//   - Ports clk, en, we, be, addr, wdata, rdata.
//   - Arbiter, FSM and response muxing stay in mem_arb_sram.
// TESTING
//  1 Reset -> m0/m1 gnt, rvalid and rdata all 0.
//    Hold rst_i for 3 cycles with m0_req=1 -> no gnt during reset.
//  2 m0 write addr 0x123, data 0xDEADBEEF, be 1111 -> gnt in the same cycle, rvalid at +1, rdata 0.
//    Then m1 reads 0x123 -> m1_rvalid at +1 with 0xDEADBEEF; m0_rvalid stays 0.
//  3 m0 write 0x11223344 with be 0101 to 0x123 -> a read returns 0xDE22BE44.
//    A write with be 0000 -> the read is still 0xDE22BE44.
//  4 m0 and m1 both hold req for 3 transactions -> grant order m0, m1, m0.
//    With MEM_ARB_FIXED_PRIO_EN -> m0, m0, m0.
//  5 WAIT_CYCLES=2, m0 read -> rvalid exactly 3 cycles after gnt.
//    m1 requesting during WAIT/RESP -> its gnt comes 4 cycles after the m0 gnt.
//  6 WAIT_CYCLES=2, m0 write 0xCAFEF00D to 0x010, rst_i pulsed in the cycle after gnt -> no rvalid.
//    After reset a read of 0x010 -> 0xCAFEF00D.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master arbitrated word memory.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic M_UART = 1'b0;
  localparam logic M_CPU  = 1'b1;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

endpackage

// File: rtl/sram_word_be.sv
// Single-port synchronous word array with per-byte write enables and a registered read port.
module sram_word_be
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BE_W-1:0]       be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];

  // Read data only moves on a read access, so it holds the word until the response phase.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be[i]) begin
            mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem_q[addr];
      end
    end
  end

endmodule

// File: rtl/mem_arb_sram.sv
// Two-master arbiter in front of a shared word memory, one transaction in flight at a time.
// Define MEM_ARB_FIXED_PRIO_EN for fixed m0 priority; default arbitration is round-robin.
module mem_arb_sram
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [BE_W-1:0]       m0_be_i,
  input  logic [WORD_W-1:0]     m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [WORD_W-1:0]     m0_rdata_o,

  input  logic                  m1_req_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [BE_W-1:0]       m1_be_i,
  input  logic [WORD_W-1:0]     m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [WORD_W-1:0]     m1_rdata_o
);

  localparam logic [1:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;

  state_e                state_q, state_d;
  logic [1:0]            waitCnt_q, waitCnt_d;
  logic                  master_q, master_d;
  logic                  we_q, we_d;
  logic                  lastGrant_q, lastGrant_d;

  logic                  anyReq;
  logic                  grantSel;
  logic                  grantEn;
  logic                  respPhase;
  logic [ADDR_WIDTH-1:0] selAddr;
  logic                  selWe;
  logic [BE_W-1:0]       selBe;
  logic [WORD_W-1:0]     selWdata;
  logic [WORD_W-1:0]     sramRdata;

  // Pick the winner among the current requesters; only acted on when the FSM is idle.
  always_comb begin
    anyReq = m0_req_i | m1_req_i;
`ifdef MEM_ARB_FIXED_PRIO_EN
    grantSel = m0_req_i ? M_UART : M_CPU;
`else
    if (m0_req_i && m1_req_i) begin
      grantSel = ~lastGrant_q;
    end else begin
      grantSel = m1_req_i ? M_CPU : M_UART;
    end
`endif
  end

  // Gating with rst_i keeps gnt low and the array untouched while reset is held.
  assign grantEn = (state_q == IDLE) && anyReq && !rst_i;

  assign selAddr  = grantSel ? m1_addr_i  : m0_addr_i;
  assign selWe    = grantSel ? m1_we_i    : m0_we_i;
  assign selBe    = grantSel ? m1_be_i    : m0_be_i;
  assign selWdata = grantSel ? m1_wdata_i : m0_wdata_i;

  sram_word_be #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_sram (
    .clk   (clk_i),
    .en    (grantEn),
    .we    (selWe),
    .be    (selBe),
    .addr  (selAddr),
    .wdata (selWdata),
    .rdata (sramRdata)
  );

  always_comb begin
    state_d     = state_q;
    waitCnt_d   = waitCnt_q;
    master_d    = master_q;
    we_d        = we_q;
    lastGrant_d = lastGrant_q;
    case (state_q)
      IDLE: begin
        if (grantEn) begin
          master_d    = grantSel;
          we_d        = selWe;
          lastGrant_d = grantSel;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d   = WAIT;
            waitCnt_d = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (waitCnt_q == 2'd0) begin
          state_d = RESP;
        end else begin
          waitCnt_d = waitCnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      waitCnt_q   <= 2'd0;
      master_q    <= M_UART;
      we_q        <= 1'b0;
      lastGrant_q <= M_CPU;
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      master_q    <= master_d;
      we_q        <= we_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  // Write responses return zero data; read data is only exposed during the response pulse.
  assign respPhase   = (state_q == RESP);
  assign m0_gnt_o    = grantEn && (grantSel == M_UART);
  assign m1_gnt_o    = grantEn && (grantSel == M_CPU);
  assign m0_rvalid_o = respPhase && (master_q == M_UART);
  assign m1_rvalid_o = respPhase && (master_q == M_CPU);
  assign m0_rdata_o  = (m0_rvalid_o && !we_q) ? sramRdata : '0;
  assign m1_rdata_o  = (m1_rvalid_o && !we_q) ? sramRdata : '0;

endmodule

// File: tb/tb_mem_arb_sram.sv
// Directed bench for mem_arb_sram: instance A uses zero wait cycles, instance B uses two.
module tb_mem_arb_sram;

  logic clk;

  logic        rstA, rstB;
  logic        m0ReqA, m0WeA, m1ReqA, m1WeA;
  logic [11:0] m0AddrA, m1AddrA;
  logic [3:0]  m0BeA, m1BeA;
  logic [31:0] m0WdataA, m1WdataA;
  logic        m0GntA, m0RvalidA, m1GntA, m1RvalidA;
  logic [31:0] m0RdataA, m1RdataA;

  logic        m0ReqB, m0WeB, m1ReqB, m1WeB;
  logic [11:0] m0AddrB, m1AddrB;
  logic [3:0]  m0BeB, m1BeB;
  logic [31:0] m0WdataB, m1WdataB;
  logic        m0GntB, m0RvalidB, m1GntB, m1RvalidB;
  logic [31:0] m0RdataB, m1RdataB;

  int total = 0;
  int bad   = 0;
  logic expOrder [3];

  mem_arb_sram #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dutA (
    .clk_i(clk), .rst_i(rstA),
    .m0_req_i(m0ReqA), .m0_addr_i(m0AddrA), .m0_we_i(m0WeA), .m0_be_i(m0BeA),
    .m0_wdata_i(m0WdataA), .m0_gnt_o(m0GntA), .m0_rvalid_o(m0RvalidA), .m0_rdata_o(m0RdataA),
    .m1_req_i(m1ReqA), .m1_addr_i(m1AddrA), .m1_we_i(m1WeA), .m1_be_i(m1BeA),
    .m1_wdata_i(m1WdataA), .m1_gnt_o(m1GntA), .m1_rvalid_o(m1RvalidA), .m1_rdata_o(m1RdataA)
  );

  mem_arb_sram #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dutB (
    .clk_i(clk), .rst_i(rstB),
    .m0_req_i(m0ReqB), .m0_addr_i(m0AddrB), .m0_we_i(m0WeB), .m0_be_i(m0BeB),
    .m0_wdata_i(m0WdataB), .m0_gnt_o(m0GntB), .m0_rvalid_o(m0RvalidB), .m0_rdata_o(m0RdataB),
    .m1_req_i(m1ReqB), .m1_addr_i(m1AddrB), .m1_we_i(m1WeB), .m1_be_i(m1BeB),
    .m1_wdata_i(m1WdataB), .m1_gnt_o(m1GntB), .m1_rvalid_o(m1RvalidB), .m1_rdata_o(m1RdataB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit onB, input bit m, input logic req, input logic we,
                               input logic [11:0] addr, input logic [3:0] be,
                               input logic [31:0] wdata);
    if (!onB && !m) begin
      m0ReqA = req; m0WeA = we; m0AddrA = addr; m0BeA = be; m0WdataA = wdata;
    end else if (!onB) begin
      m1ReqA = req; m1WeA = we; m1AddrA = addr; m1BeA = be; m1WdataA = wdata;
    end else if (!m) begin
      m0ReqB = req; m0WeB = we; m0AddrB = addr; m0BeB = be; m0WdataB = wdata;
    end else begin
      m1ReqB = req; m1WeB = we; m1AddrB = addr; m1BeB = be; m1WdataB = wdata;
    end
  endtask

  // One full transaction on the zero-wait instance: grant now, response next cycle.
  task automatic runTxnA(input bit m, input logic we, input logic [11:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input string tag);
    applyStimulus(1'b0, m, 1'b1, we, addr, be, wdata);
    #1;
    checkOutput({tag, " gnt"}, m ? m1GntA : m0GntA, 32'd1);
    checkOutput({tag, " other gnt"}, m ? m0GntA : m1GntA, 32'd0);
    tick();
    applyStimulus(1'b0, m, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    #1;
    checkOutput({tag, " rvalid"}, m ? m1RvalidA : m0RvalidA, 32'd1);
    checkOutput({tag, " rdata"}, m ? m1RdataA : m0RdataA, expRdata);
    checkOutput({tag, " other rvalid"}, m ? m0RvalidA : m1RvalidA, 32'd0);
    tick();
  endtask

  // One full transaction on the two-wait instance: response exactly three cycles after grant.
  task automatic runTxnB(input bit m, input logic we, input logic [11:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input string tag);
    applyStimulus(1'b1, m, 1'b1, we, addr, be, wdata);
    #1;
    checkOutput({tag, " gnt"}, m ? m1GntB : m0GntB, 32'd1);
    tick();
    applyStimulus(1'b1, m, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    #1;
    for (int k = 1; k <= 3; k++) begin
      checkOutput({tag, " rvalid"}, m ? m1RvalidB : m0RvalidB, 32'(k == 3));
      if (k == 3) checkOutput({tag, " rdata"}, m ? m1RdataB : m0RdataB, expRdata);
      tick();
    end
  endtask

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    expOrder[0] = 1'b0; expOrder[1] = 1'b0; expOrder[2] = 1'b0;
`else
    expOrder[0] = 1'b0; expOrder[1] = 1'b1; expOrder[2] = 1'b0;
`endif
    rstA = 1'b1;
    rstB = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 4'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);

    $display("[TB] reset with m0 requesting");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst m0 gnt", m0GntA, 32'd0);
      checkOutput("rst m1 gnt", m1GntA, 32'd0);
      checkOutput("rst m0 rvalid", m0RvalidA, 32'd0);
      checkOutput("rst m1 rvalid", m1RvalidA, 32'd0);
      checkOutput("rst m0 rdata", m0RdataA, 32'd0);
      checkOutput("rst m1 rdata", m1RdataA, 32'd0);
    end
    rstA = 1'b0;
    rstB = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    tick();

    $display("[TB] write then cross-master read");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 4'hF, 32'hDEADBEEF);
    #1;
    checkOutput("t2 m0 gnt", m0GntA, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h123, 4'h0, 32'h0);
    #1;
    checkOutput("t2 m0 rvalid", m0RvalidA, 32'd1);
    checkOutput("t2 m0 wr rdata", m0RdataA, 32'd0);
    checkOutput("t2 m1 gnt in RESP", m1GntA, 32'd0);
    tick();
    checkOutput("t2 m1 gnt", m1GntA, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    #1;
    checkOutput("t2 m1 rvalid", m1RvalidA, 32'd1);
    checkOutput("t2 m1 rdata", m1RdataA, 32'hDEADBEEF);
    checkOutput("t2 m0 rvalid idle", m0RvalidA, 32'd0);
    tick();

    $display("[TB] byte enables");
    runTxnA(1'b0, 1'b1, 12'h123, 4'b0101, 32'h11223344, 32'h0, "t3 wr be0101");
    runTxnA(1'b0, 1'b0, 12'h123, 4'h0, 32'h0, 32'hDE22BE44, "t3 rd");
    runTxnA(1'b0, 1'b1, 12'h123, 4'b0000, 32'hFFFFFFFF, 32'h0, "t3 wr be0000");
    runTxnA(1'b1, 1'b0, 12'h123, 4'h0, 32'h0, 32'hDE22BE44, "t3 rd after be0000");

    $display("[TB] contested requests after reset");
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 4'h0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 12'h123, 4'h0, 32'h0);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t4 m0 gnt", m0GntA, 32'(expOrder[k] == 1'b0));
      checkOutput("t4 m1 gnt", m1GntA, 32'(expOrder[k] == 1'b1));
      tick();
      if (k == 2) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
      end
      #1;
      checkOutput("t4 rvalid", expOrder[k] ? m1RvalidA : m0RvalidA, 32'd1);
      checkOutput("t4 rdata", expOrder[k] ? m1RdataA : m0RdataA, 32'hDE22BE44);
      tick();
    end

    $display("[TB] two wait cycles");
    runTxnB(1'b1, 1'b1, 12'h020, 4'hF, 32'h12345678, 32'h0, "t5 m1 wr");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
    #1;
    checkOutput("t5 m0 gnt", m0GntB, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h020, 4'h0, 32'h0);
    #1;
    for (int k = 1; k <= 3; k++) begin
      checkOutput("t5 m0 rvalid", m0RvalidB, 32'(k == 3));
      checkOutput("t5 m1 gnt early", m1GntB, 32'd0);
      if (k == 3) checkOutput("t5 m0 rdata", m0RdataB, 32'h12345678);
      tick();
    end
    checkOutput("t5 m1 gnt", m1GntB, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    #1;
    for (int k = 1; k <= 3; k++) begin
      checkOutput("t5 m1 rvalid", m1RvalidB, 32'(k == 3));
      if (k == 3) checkOutput("t5 m1 rdata", m1RdataB, 32'h12345678);
      tick();
    end

    $display("[TB] reset during wait");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 4'hF, 32'hCAFEF00D);
    #1;
    checkOutput("t6 m0 gnt", m0GntB, 32'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'h0, 32'h0);
    rstB = 1'b1;
    tick();
    rstB = 1'b0;
    #1;
    for (int k = 1; k <= 3; k++) begin
      checkOutput("t6 m0 rvalid dropped", m0RvalidB, 32'd0);
      checkOutput("t6 m1 rvalid dropped", m1RvalidB, 32'd0);
      tick();
    end
    runTxnB(1'b0, 1'b0, 12'h010, 4'h0, 32'h0, 32'hCAFEF00D, "t6 rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
